// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
// Walks a range of architectural register ids on the core's read-out port,
// captures each returned value and streams (id, data) pairs over valid/ready.
// Ids wrap NREGS-1 -> 0, so a range with first > last dumps through the top.
// RD_LAT is the read latency of the core's port (0..3 clocks).
module reg_dump_sequencer #(
  parameter int NREGS  = 32,
  parameter int ID_W   = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ID_W-1:0]   first_id,
  input  logic [ID_W-1:0]   last_id,
  output logic [ID_W-1:0]   reg_out_id,
  input  logic [DATA_W-1:0] reg_out_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ID_W-1:0]   dump_id,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [1:0]      LAT_INIT = 2'(RD_LAT);
  localparam logic [ID_W-1:0] TOP_ID   = ID_W'(NREGS - 1);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     cur_reg, cur_next;
  logic [ID_W-1:0]     last_reg, last_next;
  logic [1:0]          wcnt_reg, wcnt_next;
  logic [ID_W-1:0]     reg_out_id_reg, reg_out_id_next;
  logic                dump_valid_reg, dump_valid_next;
  logic [ID_W-1:0]     dump_id_reg, dump_id_next;
  logic [DATA_W-1:0]   dump_data_reg, dump_data_next;

  // Successor id with wrap from the top register back to 0.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
    if (x == TOP_ID) return '0;
    else             return x + 1'b1;
  endfunction

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cur_reg        <= '0;
      last_reg       <= '0;
      wcnt_reg       <= '0;
      reg_out_id_reg <= '0;
      dump_valid_reg <= 1'b0;
      dump_id_reg    <= '0;
      dump_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      last_reg       <= last_next;
      wcnt_reg       <= wcnt_next;
      reg_out_id_reg <= reg_out_id_next;
      dump_valid_reg <= dump_valid_next;
      dump_id_reg    <= dump_id_next;
      dump_data_reg  <= dump_data_next;
    end
  end

  // Next-state logic: issue id, wait out the read latency, hold pair until accepted.
  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    last_next       = last_reg;
    wcnt_next       = wcnt_reg;
    reg_out_id_next = reg_out_id_reg;
    dump_valid_next = dump_valid_reg;
    dump_id_next    = dump_id_reg;
    dump_data_next  = dump_data_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          cur_next        = first_id;
          last_next       = last_id;
          reg_out_id_next = first_id;
          wcnt_next       = LAT_INIT;
          state_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_reg != 2'd0) begin
          wcnt_next = wcnt_reg - 2'd1;
        end else begin
          dump_data_next  = reg_out_data;
          dump_id_next    = cur_reg;
          dump_valid_next = 1'b1;
          state_next      = S_SEND;
        end
      end
      S_SEND: begin
        if (dump_valid_reg && dump_ready) begin
          dump_valid_next = 1'b0;
          if (cur_reg == last_reg) begin
            state_next = S_DONE;
          end else begin
            cur_next        = next_id(cur_reg);
            reg_out_id_next = next_id(cur_reg);
            wcnt_next       = LAT_INIT;
            state_next      = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a final handshake on the same edge,
    // so the DONE state (and its pulse) is never reached after an abort.
    if (abort && (state_reg != S_IDLE)) begin
      state_next      = S_IDLE;
      dump_valid_next = 1'b0;
      reg_out_id_next = reg_out_id_reg;
    end
  end

  assign reg_out_id = reg_out_id_reg;
  assign dump_valid = dump_valid_reg;
  assign dump_id    = dump_id_reg;
  assign dump_data  = dump_data_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb_reg_dump_sequencer
// Directed bench for reg_dump_sequencer against a behavioural register file
// with two clocks of read latency. Expected pairs are queued when a dump is
// started and popped as the consumer accepts each pair.
module tb_reg_dump_sequencer;

  localparam int NREGS  = 32;
  localparam int ID_W   = 5;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ID_W-1:0]   first_id = '0;
  logic [ID_W-1:0]   last_id = '0;
  logic [ID_W-1:0]   reg_out_id;
  logic [DATA_W-1:0] reg_out_data;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [ID_W-1:0]   dump_id;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;

  reg_dump_sequencer #(
    .NREGS (NREGS),
    .ID_W  (ID_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .first_id    (first_id),
    .last_id     (last_id),
    .reg_out_id  (reg_out_id),
    .reg_out_data(reg_out_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_id     (dump_id),
    .dump_data   (dump_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Behavioural core register file with RD_LAT=2 read pipeline.
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] pipe0 = '0;
  logic [DATA_W-1:0] pipe1 = '0;
  always @(posedge clock) begin
    pipe0 <= regs[reg_out_id];
    pipe1 <= pipe0;
  end
  assign reg_out_data = pipe1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } pair_t;

  pair_t             q[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                done_cnt = 0;
  int                last_hs = 0;
  int                d0;
  bit                have_prev = 1'b0;
  bit                check_period = 1'b0;
  bit                prev_stall = 1'b0;
  bit                prev_done = 1'b0;
  logic [ID_W-1:0]   prev_id = '0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pair(input int id, input logic [DATA_W-1:0] data);
    pair_t p;
    p.id   = ID_W'(id);
    p.data = data;
    q.push_back(p);
  endtask

  // Sampled on the falling edge: scoreboard, stall stability, done width, spacing.
  task automatic monitor();
    pair_t p;
    cyc++;
    if (done) begin
      chk("done_width", prev_done, 0);
      done_cnt++;
    end
    if (prev_stall) begin
      chk("stall_valid", dump_valid, 1);
      chk("stall_id", dump_id, prev_id);
      chk("stall_data", dump_data, prev_data);
    end
    if (dump_valid && dump_ready && reset) begin
      chk("pair_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        p = q.pop_front();
        $display("pair id=%0d data=%0d (expect id=%0d data=%0d)", dump_id, dump_data, p.id, p.data);
        chk("pair_id", dump_id, p.id);
        chk("pair_data", dump_data, p.data);
      end
      if (check_period && have_prev) chk("valid_spacing", cyc - last_hs, RD_LAT + 2);
      last_hs   = cyc;
      have_prev = 1'b1;
    end
    if (!busy) have_prev = 1'b0;
    prev_stall = dump_valid && !dump_ready && !abort && reset;
    prev_id    = dump_id;
    prev_data  = dump_data;
    prev_done  = done;
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dump(input int f, input int l);
    first_id = ID_W'(f);
    last_id  = ID_W'(l);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      if (rnd) dump_ready = ($urandom_range(0, 9) < 3);
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_valid_id(input int id);
    int n;
    n = 0;
    while (!(dump_valid && dump_id == ID_W'(id)) && n < 100) begin
      tick();
      n++;
    end
    chk("valid_timeout", (dump_valid && dump_id == ID_W'(id)), 1);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regs[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_reg_out_id", reg_out_id, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_id", dump_id, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    tick();

    // Test 1: core program result, dump 10..12
    regs[10] = regs[5] + 32'd7;
    regs[11] = regs[10] + 32'd8;
    regs[12] = regs[10] + regs[11];
    expect_pair(10, 7);
    expect_pair(11, 15);
    expect_pair(12, 22);
    dump_ready = 1'b1;
    d0 = done_cnt;
    start_dump(10, 12);
    chk("busy_after_start", busy, 1);
    wait_idle(0);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // Test 2: full dump with reg[i]=i*3, spacing RD_LAT+2
    for (int i = 0; i < NREGS; i++) regs[i] = DATA_W'(i * 3);
    for (int i = 0; i < NREGS; i++) expect_pair(i, DATA_W'(i * 3));
    check_period = 1'b1;
    d0 = done_cnt;
    start_dump(0, 31);
    wait_idle(0);
    check_period = 1'b0;
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_idle_reg_out_id", reg_out_id, 31);

    // Test 3: wrap-around 30..1, then a single register
    expect_pair(30, 90);
    expect_pair(31, 93);
    expect_pair(0, 0);
    expect_pair(1, 3);
    d0 = done_cnt;
    start_dump(30, 1);
    wait_idle(0);
    chk("t3_wrap_done", done_cnt - d0, 1);
    expect_pair(7, 21);
    d0 = done_cnt;
    start_dump(7, 7);
    wait_idle(0);
    chk("t3_single_done", done_cnt - d0, 1);

    // Test 4: random backpressure at ~30% ready
    for (int i = 5; i <= 20; i++) expect_pair(i, DATA_W'(i * 3));
    dump_ready = 1'b0;
    start_dump(5, 20);
    wait_idle(1);
    dump_ready = 1'b1;

    // Test 5: abort while the second pair is held
    dump_ready = 1'b0;
    for (int i = 0; i <= 5; i++) expect_pair(i, DATA_W'(i * 3));
    d0 = done_cnt;
    start_dump(0, 5);
    wait_valid_id(0);
    dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    wait_valid_id(1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", dump_valid, 0);
    chk("abort_reg_out_id", reg_out_id, 1);
    chk("abort_pending", q.size(), 5);
    q.delete();
    tick();
    tick();
    tick();
    chk("abort_no_done", done_cnt - d0, 0);
    expect_pair(3, 9);
    expect_pair(4, 12);
    dump_ready = 1'b1;
    d0 = done_cnt;
    start_dump(3, 4);
    wait_idle(0);
    chk("t5_restart_done", done_cnt - d0, 1);

    // Test 6: asynchronous reset during WAIT, then start ignored while busy
    dump_ready = 1'b0;
    d0 = done_cnt;
    start_dump(5, 6);
    tick();
    reset = 1'b0;
    #1;
    chk("arst_reg_out_id", reg_out_id, 0);
    chk("arst_dump_valid", dump_valid, 0);
    chk("arst_dump_id", dump_id, 0);
    chk("arst_dump_data", dump_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("arst_no_done", done_cnt - d0, 0);
    expect_pair(5, 15);
    expect_pair(6, 18);
    d0 = done_cnt;
    start_dump(5, 6);
    repeat (4) tick();
    start_dump(20, 25);
    dump_ready = 1'b1;
    wait_idle(0);
    chk("t6_done", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
